// File: rtl/ahb_bridge_pkg.sv
// ahb_bridge_pkg: FSM states, AHB encodings and default wait limit for the MMIO bridge
package ahb_bridge_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD, RD_RESP, ERR1, ERR2} state_e;
  localparam logic [1:0] HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/ahb_lane_dec.sv
// ahb_lane_dec: byte-lane mask and alignment check from HSIZE and HADDR[1:0]
module ahb_lane_dec
  import ahb_bridge_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       misaligned
);
  // sizes above a word have no lane mapping and are always flagged
  always_comb begin
    mask = (hsize == HSIZE_BYTE) ? 4'b0001 << addr_lo :
           (hsize == HSIZE_HALF) ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
           (hsize == HSIZE_WORD) ? 4'b1111 : 4'b0000;
    misaligned = (hsize == HSIZE_BYTE) ? 1'b0 :
                 (hsize == HSIZE_HALF) ? addr_lo[0] :
                 (hsize == HSIZE_WORD) ? |addr_lo : 1'b1;
  end
endmodule

// File: rtl/ahb_mmio_bridge_v2.sv
// ahb_mmio_bridge_v2: AHB-Lite slave to MMIO bridge; AHB_BRIDGE_TIMEOUT_EN adds a wait-cycle timeout
module ahb_mmio_bridge_v2
  import ahb_bridge_pkg::*;
#(
  parameter int AWIDTH  = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HADDR,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic              MMIO_EN,
  output logic [3:0]        MMIO_WEA,
  output logic [AWIDTH-3:0] MMIO_ADDR,
  output logic [31:0]       MMIO_DIN,
  input  logic [31:0]       MMIO_DOUT,
  input  logic              MMIO_RDY
);
  state_e            state_q, state_d;
  logic [AWIDTH-3:0] addr_q, addr_d;
  logic [3:0]        mask_q, mask_d, lane_mask;
  logic [31:0]       rdata_q, rdata_d;
  logic              misaligned, accept, tmo;
  logic              unused_haddr;

  assign unused_haddr = ^HADDR[31:AWIDTH];
  assign MMIO_ADDR    = addr_q;
  assign MMIO_DIN     = HWDATA;
  assign HRDATA       = rdata_q;

  ahb_lane_dec u_dec (
    .hsize     (HSIZE),
    .addr_lo   (HADDR[1:0]),
    .mask      (lane_mask),
    .misaligned(misaligned)
  );

`ifdef AHB_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign tmo = !MMIO_RDY && cnt_q == 8'(TIMEOUT - 1);

  // wait counter restarts on every accepted transfer and counts stalled MMIO cycles
  always_comb begin
    cnt_d = accept ? 8'd0 : ((state_q == WR || state_q == RD) && !MMIO_RDY) ? cnt_q + 8'd1 : cnt_q;
  end

  // wait counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // per-state outputs and next state; an accepted address phase overrides the next state
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    rdata_d   = rdata_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    MMIO_EN   = 1'b0;
    MMIO_WEA  = 4'b0000;
    case (state_q)
      WR: begin
        MMIO_EN   = 1'b1;
        MMIO_WEA  = mask_q;
        HREADYOUT = MMIO_RDY;
        state_d   = MMIO_RDY ? IDLE : tmo ? ERR1 : WR;
      end
      RD: begin
        MMIO_EN   = 1'b1;
        HREADYOUT = 1'b0;
        rdata_d   = MMIO_RDY ? MMIO_DOUT : rdata_q;
        state_d   = MMIO_RDY ? RD_RESP : tmo ? ERR1 : RD;
      end
      ERR1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
        state_d   = ERR2;
      end
      ERR2: begin
        HRESP   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    if (accept) begin
      addr_d  = HADDR[AWIDTH-1:2];
      mask_d  = lane_mask;
      state_d = misaligned ? ERR1 : HWRITE ? WR : RD;
    end
  end

  // state, request and read-data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: doc/ahb_mmio_bridge_v2.md
AHB_MMIO_BRIDGE_V2 -- requirements
Module: ahb_mmio_bridge_v2

Interface
REQ-001 SHALL have parameter AWIDTH, default 16, meaning the MMIO byte-address width; MMIO_ADDR carries word addresses of AWIDTH-2 bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning the maximum wait cycles for MMIO_RDY before an error response (valid range 1..255).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 HSEL, HREADY, HWRITE  input  1 each  AHB-Lite select, bus-ready and write indicator.
REQ-007 HTRANS  input  2  AHB transfer type; only bit 1 set (NONSEQ/SEQ) starts a transfer.
REQ-008 HADDR  input  32, HSIZE  input  3, HWDATA  input  32  AHB address, size and write data.
REQ-009 HREADYOUT  output  1, HRESP  output  1, HRDATA  output  32  AHB slave response.
REQ-010 MMIO_EN  output  1, MMIO_WEA  output  4, MMIO_ADDR  output  AWIDTH-2, MMIO_DIN  output  32  MMIO request.
REQ-011 MMIO_DOUT  input  32, MMIO_RDY  input  1  MMIO read data and completion handshake.

Function
REQ-012 Address phase SHALL be accepted when HSEL && HREADY && HTRANS[1] and the FSM is in IDLE or in a data-phase cycle with HREADYOUT=1.
REQ-013 On accept, SHALL register word address HADDR[AWIDTH-1:2], HWRITE, and byte-lane mask (HSIZE 0/1/2 with HADDR[1:0]: byte lane, halfword 4'b0011/4'b1100, word 4'b1111).
REQ-014 Accept with HSIZE>2, or with misaligned halfword/word HADDR[1:0], SHALL go to ERR1 without issuing MMIO_EN.
REQ-015 FSM states SHALL be IDLE, WR, RD, RD_RESP, ERR1, ERR2.
REQ-016 WR: MMIO_EN=1, MMIO_WEA=registered mask, MMIO_DIN=HWDATA; MMIO_ADDR, MMIO_WEA held stable; HREADYOUT=MMIO_RDY; on MMIO_RDY go to IDLE, or directly to WR/RD/ERR1 if a new transfer is accepted that cycle.
REQ-017 RD: MMIO_EN=1, MMIO_WEA=0, HREADYOUT=0; on MMIO_RDY capture MMIO_DOUT into the read register and go to RD_RESP.
REQ-018 RD_RESP: MMIO_EN=0, HREADYOUT=1, HRDATA=captured data; a read therefore costs minimum one wait state, a write zero.
REQ-019 HRDATA SHALL hold the last captured value in all other states.
REQ-020 ERR1: HRESP=1, HREADYOUT=0; ERR2: HRESP=1, HREADYOUT=1, then IDLE; no transfer SHALL be accepted in ERR1.
REQ-021 HRESP SHALL be 0 in every state except ERR1/ERR2.
REQ-022 IDLE: HREADYOUT=1, MMIO_EN=0, MMIO_WEA=0.
REQ-023 HTRANS IDLE/BUSY with HSEL=1 SHALL give a zero-wait OKAY and not start a transfer.
REQ-024 MMIO_RDY SHALL be ignored outside WR and RD.

Reset
REQ-025 Reset assertion SHALL immediately force state IDLE, HREADYOUT=1, HRESP=0, MMIO_EN=0, MMIO_WEA=0, HRDATA register=0, wait counter=0, registered address/mask=0.
REQ-026 Reset mid-transfer SHALL abandon the transfer; no MMIO strobe SHALL appear in the first cycle after deassertion.

Configuration
REQ-027 Macro AHB_BRIDGE_TIMEOUT_EN defined: an 8-bit wait counter SHALL clear on entry to WR/RD, increment each cycle MMIO_RDY=0, and when it reaches TIMEOUT drop MMIO_EN and go to ERR1.
REQ-028 Macro undefined: no counter SHALL be present; WR/RD wait indefinitely for MMIO_RDY.

Structure
REQ-029 Package ahb_bridge_pkg SHALL hold the FSM state enum, HTRANS and HSIZE encodings, and the default TIMEOUT constant.
REQ-030 Byte-lane decode and alignment check SHALL be one combinational sub-module ahb_lane_dec (inputs HSIZE, HADDR[1:0]; outputs mask, misaligned).

Verification
REQ-031 Word write 0xDEADBEEF to 0x0010, MMIO_RDY=1 -> MMIO_EN=1, WEA=4'b1111, ADDR=0x004 in data phase, HREADYOUT=1, zero waits.
REQ-032 Byte read at 0x0013, MMIO_RDY low 3 cycles, DOUT=0x11223344 -> HREADYOUT low 4 cycles, then HRDATA=0x11223344, HRESP=0.
REQ-033 Halfword write at 0x0001 -> two-cycle ERROR (HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1), MMIO_EN never high.
REQ-034 Back-to-back write then read, MMIO_RDY=1 -> read address accepted in write data phase, no idle cycle, WEA=0 during read.
REQ-035 With AHB_BRIDGE_TIMEOUT_EN, TIMEOUT=4, MMIO_RDY stuck 0 -> after 4 wait cycles MMIO_EN=0 and ERROR response.
REQ-036 Reset asserted during RD wait -> outputs at reset values asynchronously; next transfer after release completes normally.
